vga_sync_decoder: RTL and testbench

VGA_SYNC_DECODER -- requirements
Module: vga_sync_decoder

---
 rtl/vga_sync_decoder.sv | 212 +++++++++++++++++++++
 tb/tb_vga_sync_decoder.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/vga_sync_decoder.sv
// Recovers pixel coordinates, line/frame timing and lock status from a raw VGA
// sync + RGB stream clocked by the pixel clock.
module vga_sync_decoder #(
  parameter int unsigned H_ACTIVE = 640,
  parameter int unsigned H_BACK   = 48,
  parameter int unsigned H_TOTAL  = 800,
  parameter int unsigned V_ACTIVE = 480,
  parameter int unsigned V_BACK   = 33,
  parameter int unsigned V_TOTAL  = 525
) (
  input  logic        clk_25_175,
  input  logic        reset,
  input  logic        h_sync,
  input  logic        v_sync,
  input  logic [3:0]  r,
  input  logic [3:0]  g,
  input  logic [3:0]  b,
  output logic [9:0]  pix_x,
  output logic [9:0]  pix_y,
  output logic [11:0] pix_data,
  output logic        pix_valid,
  output logic        frame_start,
  output logic        locked,
  output logic [10:0] line_len,
  output logic [9:0]  frame_lines,
  output logic [7:0]  err_count
);

  typedef enum logic [1:0] {StSearch, StMeasure, StLocked} state_e;

  localparam logic [10:0] HCntMax = 11'h7ff;
  localparam logic [9:0]  VCntMax = 10'h3ff;
  localparam logic [10:0] HTotal  = 11'(H_TOTAL);
  localparam logic [10:0] HVisLo  = 11'(H_BACK);
  localparam logic [10:0] HVisHi  = 11'(H_BACK + H_ACTIVE);
  localparam logic [9:0]  VTotal  = 10'(V_TOTAL);
  localparam logic [9:0]  VVisLo  = 10'(V_BACK);
  localparam logic [9:0]  VVisHi  = 10'(V_BACK + V_ACTIVE);

  logic        h_s1_q, v_s1_q, h_s2_q, v_s2_q;
  logic [11:0] rgb_s1_q;

  logic [10:0] hcnt_q, hcnt_d;
  logic [9:0]  vcnt_q, vcnt_d;
  logic        v_pending_q, v_pending_d;
  logic [10:0] line_len_q, line_len_d;
  logic [9:0]  frame_lines_q, frame_lines_d;
  logic [7:0]  err_q, err_d;
  logic        lines_ok_q, lines_ok_d;
  state_e      state_q, state_d;

  logic [9:0]  pix_x_q, pix_x_d;
  logic [9:0]  pix_y_q, pix_y_d;
  logic [11:0] pix_data_q, pix_data_d;
  logic        pix_valid_q, pix_valid_d;
  logic        frame_start_q, frame_start_d;

  logic h_edge, v_edge, commit, line_load, line_bad, frame_bad, h_sat;
  logic h_vis, v_vis;

  assign h_edge    = h_s1_q & ~h_s2_q;
  assign v_edge    = v_s1_q & ~v_s2_q;
  // A v-edge arriving together with the h-edge commits the frame on that same h-edge.
  assign commit    = h_edge & (v_pending_q | v_edge);
  assign line_load = h_edge & (hcnt_q != HCntMax);

  // hcnt_d/vcnt_d are the counts belonging to the pixel currently held in S1;
  // hcnt_q/vcnt_q are the counts of the previous S1 pixel.
  always_comb begin
    hcnt_d        = hcnt_q;
    vcnt_d        = vcnt_q;
    v_pending_d   = v_pending_q;
    line_len_d    = line_len_q;
    frame_lines_d = frame_lines_q;

    if (h_edge) begin
      hcnt_d = '0;
    end else if (hcnt_q != HCntMax) begin
      hcnt_d = hcnt_q + 11'd1;
    end

    if (line_load) begin
      line_len_d = hcnt_q + 11'd1;
    end

    if (commit) begin
      frame_lines_d = vcnt_q + 10'd1;
      vcnt_d        = '0;
      v_pending_d   = 1'b0;
    end else begin
      if (h_edge && vcnt_q != VCntMax) begin
        vcnt_d = vcnt_q + 10'd1;
      end
      if (v_edge) begin
        v_pending_d = 1'b1;
      end
    end
  end

  assign line_bad  = line_load && (line_len_d != HTotal);
  assign frame_bad = commit && (frame_lines_d != VTotal);
  assign h_sat     = (hcnt_d == HCntMax);

  always_comb begin
    state_d    = state_q;
    err_d      = err_q;
    lines_ok_d = lines_ok_q;

    if (line_bad) begin
      lines_ok_d = 1'b0;
    end

    case (state_q)
      StSearch: begin
        if (commit) begin
          state_d = StMeasure;
        end
      end
      StMeasure: begin
        if (h_sat) begin
          state_d = StSearch;
        end else if (commit && !frame_bad && lines_ok_q && !line_bad) begin
          state_d = StLocked;
        end
      end
      StLocked: begin
        if (line_bad || frame_bad || h_sat) begin
          state_d = StSearch;
          if (err_q != 8'hff) begin
            err_d = err_q + 8'd1;
          end
        end
      end
      default: state_d = StSearch;
    endcase

    // The line ending on a commit belongs to the frame just closed.
    if (commit) begin
      lines_ok_d = 1'b1;
    end
  end

  assign h_vis = (hcnt_d >= HVisLo) && (hcnt_d < HVisHi);
  assign v_vis = (vcnt_d >= VVisLo) && (vcnt_d < VVisHi);

  always_comb begin
    pix_valid_d   = h_vis && v_vis && (state_q == StLocked);
    pix_x_d       = '0;
    pix_y_d       = '0;
    pix_data_d    = '0;
    frame_start_d = 1'b0;
    if (pix_valid_d) begin
      pix_x_d       = 10'(hcnt_d - HVisLo);
      pix_y_d       = vcnt_d - VVisLo;
      pix_data_d    = rgb_s1_q;
      frame_start_d = (hcnt_d == HVisLo) && (vcnt_d == VVisLo);
    end
  end

  always_ff @(posedge clk_25_175) begin
    if (reset) begin
      h_s1_q        <= 1'b1;
      v_s1_q        <= 1'b1;
      h_s2_q        <= 1'b1;
      v_s2_q        <= 1'b1;
      rgb_s1_q      <= '0;
      hcnt_q        <= '0;
      vcnt_q        <= '0;
      v_pending_q   <= 1'b0;
      line_len_q    <= '0;
      frame_lines_q <= '0;
      err_q         <= '0;
      lines_ok_q    <= 1'b0;
      state_q       <= StSearch;
      pix_x_q       <= '0;
      pix_y_q       <= '0;
      pix_data_q    <= '0;
      pix_valid_q   <= 1'b0;
      frame_start_q <= 1'b0;
    end else begin
      h_s1_q        <= h_sync;
      v_s1_q        <= v_sync;
      h_s2_q        <= h_s1_q;
      v_s2_q        <= v_s1_q;
      rgb_s1_q      <= {b, g, r};
      hcnt_q        <= hcnt_d;
      vcnt_q        <= vcnt_d;
      v_pending_q   <= v_pending_d;
      line_len_q    <= line_len_d;
      frame_lines_q <= frame_lines_d;
      err_q         <= err_d;
      lines_ok_q    <= lines_ok_d;
      state_q       <= state_d;
      pix_x_q       <= pix_x_d;
      pix_y_q       <= pix_y_d;
      pix_data_q    <= pix_data_d;
      pix_valid_q   <= pix_valid_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign pix_x       = pix_x_q;
  assign pix_y       = pix_y_q;
  assign pix_data    = pix_data_q;
  assign pix_valid   = pix_valid_q;
  assign frame_start = frame_start_q;
  assign locked      = (state_q == StLocked);
  assign line_len    = line_len_q;
  assign frame_lines = frame_lines_q;
  assign err_count   = err_q;

endmodule

// File: tb/tb_vga_sync_decoder.sv
// Directed bench for vga_sync_decoder on a scaled-down raster (100 x 30 clocks)
// so that many frames fit in a short run.
module tb_vga_sync_decoder;

  localparam int HA = 64;
  localparam int HB = 12;
  localparam int HT = 100;
  localparam int HS = 16;  // h_sync low width
  localparam int VA = 20;
  localparam int VB = 4;
  localparam int VT = 30;
  localparam int VS = 2;   // v_sync low width, in lines

  logic        clk_25_175;
  logic        reset;
  logic        h_sync, v_sync;
  logic [3:0]  r, g, b;
  logic [9:0]  pix_x, pix_y;
  logic [11:0] pix_data;
  logic        pix_valid, frame_start, locked;
  logic [10:0] line_len;
  logic [9:0]  frame_lines;
  logic [7:0]  err_count;

  vga_sync_decoder #(
    .H_ACTIVE(HA), .H_BACK(HB), .H_TOTAL(HT),
    .V_ACTIVE(VA), .V_BACK(VB), .V_TOTAL(VT)
  ) dut (
    .clk_25_175 (clk_25_175),
    .reset      (reset),
    .h_sync     (h_sync),
    .v_sync     (v_sync),
    .r          (r),
    .g          (g),
    .b          (b),
    .pix_x      (pix_x),
    .pix_y      (pix_y),
    .pix_data   (pix_data),
    .pix_valid  (pix_valid),
    .frame_start(frame_start),
    .locked     (locked),
    .line_len   (line_len),
    .frame_lines(frame_lines),
    .err_count  (err_count)
  );

  initial clk_25_175 = 1'b0;
  always #5 clk_25_175 = ~clk_25_175;

  typedef struct {
    int          v;
    int          h;
    logic [3:0]  r;
    logic [3:0]  g;
    logic [3:0]  b;
    int          x;
    int          y;
    logic [11:0] data;
    logic        valid;
    logic        fs;
  } vec_t;

  vec_t tbl[9];

  int total = 0;
  int bad   = 0;
  int pos_h = 0;
  int pos_v = 0;
  bit coinc = 1'b0;
  int fs_cnt = 0;
  bit valid_seen = 1'b0;

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // One pixel clock: apply inputs, take the edge, sample 1 time unit later.
  task automatic drive(input logic hs, input logic vs,
                       input logic [3:0] rr, input logic [3:0] gg, input logic [3:0] bb);
    h_sync = hs;
    v_sync = vs;
    r = rr;
    g = gg;
    b = bb;
    @(posedge clk_25_175);
    #1;
    if (frame_start) fs_cnt++;
    if (pix_valid) valid_seen = 1'b1;
  endtask

  task automatic adv(input logic [3:0] rr, input logic [3:0] gg, input logic [3:0] bb);
    logic hs, vs;
    hs = (pos_h >= HS);
    vs = !((pos_v < VS) || (coinc && pos_v == VS && pos_h < HS));
    drive(hs, vs, rr, gg, bb);
    pos_h++;
    if (pos_h == HT) begin
      pos_h = 0;
      pos_v++;
      if (pos_v == VT) pos_v = 0;
    end
  endtask

  task automatic run_to(input int v, input int h);
    while (!(pos_v == v && pos_h == h)) adv(4'h0, 4'h0, 4'h0);
  endtask

  // Drive through the next frame commit and sample once the FSM has reacted.
  task automatic pass_commit(input string name, input int exp_locked);
    run_to(VS, HS);
    adv(4'h0, 4'h0, 4'h0);
    adv(4'h0, 4'h0, 4'h0);
    check(name, int'(locked), exp_locked);
  endtask

  initial begin
    tbl[0] = '{5,  50, 4'hA, 4'hA, 4'hA, 0,  0,  12'h000, 1'b0, 1'b0};
    tbl[1] = '{6,  28, 4'h5, 4'hA, 4'h3, 0,  0,  12'h3A5, 1'b1, 1'b1};
    tbl[2] = '{6,  30, 4'h1, 4'h2, 4'h3, 2,  0,  12'h321, 1'b1, 1'b0};
    tbl[3] = '{6,  92, 4'h7, 4'h7, 4'h7, 0,  0,  12'h000, 1'b0, 1'b0};
    tbl[4] = '{7,  27, 4'h9, 4'h9, 4'h9, 0,  0,  12'h000, 1'b0, 1'b0};
    tbl[5] = '{7,  91, 4'hF, 4'hF, 4'hF, 63, 1,  12'hFFF, 1'b1, 1'b0};
    tbl[6] = '{25, 28, 4'h2, 4'h4, 4'h8, 0,  19, 12'h842, 1'b1, 1'b0};
    tbl[7] = '{25, 91, 4'h6, 4'h5, 4'h4, 63, 19, 12'h456, 1'b1, 1'b0};
    tbl[8] = '{26, 50, 4'h3, 4'h3, 4'h3, 0,  0,  12'h000, 1'b0, 1'b0};

    reset = 1'b1;
    h_sync = 1'b1;
    v_sync = 1'b1;
    r = 4'h0;
    g = 4'h0;
    b = 4'h0;
    repeat (3) @(posedge clk_25_175);
    #1;
    check("rst_locked", int'(locked), 0);
    check("rst_pix_valid", int'(pix_valid), 0);
    check("rst_pix_data", int'(pix_data), 0);
    check("rst_frame_start", int'(frame_start), 0);
    check("rst_line_len", int'(line_len), 0);
    check("rst_frame_lines", int'(frame_lines), 0);
    check("rst_err_count", int'(err_count), 0);
    reset = 1'b0;

    // Acquire lock: first commit -> measuring, second clean commit -> locked.
    pass_commit("lock_commit1", 0);
    pass_commit("lock_commit2", 1);
    check("lock_line_len", int'(line_len), HT);
    check("lock_frame_lines", int'(frame_lines), VT);

    // Pixel probes across one locked frame.
    fs_cnt = 0;
    for (int i = 0; i < 9; i++) begin
      run_to(tbl[i].v, tbl[i].h);
      adv(tbl[i].r, tbl[i].g, tbl[i].b);
      adv(4'h0, 4'h0, 4'h0);
      check($sformatf("vec%0d_valid", i), int'(pix_valid), int'(tbl[i].valid));
      check($sformatf("vec%0d_x", i), int'(pix_x), tbl[i].x);
      check($sformatf("vec%0d_y", i), int'(pix_y), tbl[i].y);
      check($sformatf("vec%0d_data", i), int'(pix_data), int'(tbl[i].data));
      check($sformatf("vec%0d_fs", i), int'(frame_start), int'(tbl[i].fs));
    end
    run_to(VS, HS);
    check("frame_start_per_frame", fs_cnt, 1);

    // Line 10 shortened by one clock.
    run_to(10, HT - 1);
    pos_h = 0;
    pos_v = 11;
    run_to(11, HS);
    adv(4'h0, 4'h0, 4'h0);
    check("short_still_locked", int'(locked), 1);
    adv(4'h0, 4'h0, 4'h0);
    check("short_locked", int'(locked), 0);
    check("short_err_count", int'(err_count), 1);
    valid_seen = 1'b0;
    pass_commit("short_relock1", 0);
    pass_commit("short_relock2", 1);
    check("short_no_valid", int'(valid_seen), 0);
    check("short_line_len", int'(line_len), HT);

    // h_sync held high: hcnt of the S1 pixel is 3 when the hold starts.
    run_to(10, 20);
    repeat (2044) drive(1'b1, 1'b1, 4'h0, 4'h0, 4'h0);
    check("hold_pre_sat_locked", int'(locked), 1);
    drive(1'b1, 1'b1, 4'h0, 4'h0, 4'h0);
    check("hold_sat_locked", int'(locked), 0);
    check("hold_err_count", int'(err_count), 2);
    repeat (2100 - 2045) drive(1'b1, 1'b1, 4'h0, 4'h0, 4'h0);
    run_to(11, HS);
    adv(4'h0, 4'h0, 4'h0);
    adv(4'h0, 4'h0, 4'h0);
    check("hold_line_len_kept", int'(line_len), HT);
    pass_commit("hold_relock1", 0);
    pass_commit("hold_relock2", 1);

    // v_sync rising on the same clock as h_sync.
    coinc = 1'b1;
    pass_commit("coinc_locked", 1);
    check("coinc_frame_lines", int'(frame_lines), VT);
    run_to(VS + 1, HS);
    adv(4'h0, 4'h0, 4'h0);
    adv(4'h0, 4'h0, 4'h0);
    check("coinc_next_line_locked", int'(locked), 1);
    check("coinc_err_count", int'(err_count), 2);
    coinc = 1'b0;

    // One-cycle reset in the middle of the visible area.
    run_to(15, 50);
    check("midrst_pre_valid", int'(pix_valid), 1);
    reset = 1'b1;
    adv(4'h0, 4'h0, 4'h0);
    reset = 1'b0;
    check("midrst_pix_valid", int'(pix_valid), 0);
    check("midrst_pix_x", int'(pix_x), 0);
    check("midrst_pix_y", int'(pix_y), 0);
    check("midrst_pix_data", int'(pix_data), 0);
    check("midrst_frame_start", int'(frame_start), 0);
    check("midrst_locked", int'(locked), 0);
    check("midrst_line_len", int'(line_len), 0);
    check("midrst_frame_lines", int'(frame_lines), 0);
    check("midrst_err_count", int'(err_count), 0);
    pass_commit("midrst_relock1", 0);
    pass_commit("midrst_relock2", 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
